lp_input_bram_loader: RTL and testbench

Streaming loader that fills the linear-projection input matrix BRAM through its two write ports. It accepts matrix-A words on a valid/ready stream and pairs them into simultaneous port-A (even address) and port-B (odd address) writes. It drives the `in_mat_*` write interface of `top_lp_buffer`, so that interface can be fed from a DMA or AXI-Stream source instead of a bench. An odd word count is closed with a tail write that duplicates the last word on both ports.

---
 rtl/lp_input_bram_loader.sv | 168 ++++++++++++++++
 tb/tb_lp_input_bram_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lp_input_bram_loader.sv
// Streaming loader for the linear-projection input BRAM: pairs stream words into
// simultaneous even (port A) / odd (port B) writes, closing odd counts with a duplicated tail.
module lp_input_bram_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  in_mat_ena,
  output logic                  in_mat_wea,
  output logic [ADDR_WIDTH-1:0] in_mat_wr_addra,
  output logic [DATA_WIDTH-1:0] in_mat_dina,
  output logic                  in_mat_enb,
  output logic                  in_mat_web,
  output logic [ADDR_WIDTH-1:0] in_mat_wr_addrb,
  output logic [DATA_WIDTH-1:0] in_mat_dinb,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         n_reg, n_next;
  logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] hold_reg, hold_next;
  logic                  wr_reg, wr_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;
  logic [ADDR_WIDTH-1:0] addra_reg, addra_next;
  logic [ADDR_WIDTH-1:0] addrb_reg, addrb_next;
  logic [DATA_WIDTH-1:0] dina_reg, dina_next;
  logic [DATA_WIDTH-1:0] dinb_reg, dinb_next;

  logic [CW-1:0] two_i, two_i_p1, two_i_p2, clamped;
  logic          handshake;

  // Pair arithmetic is done one bit wider than the address so that N = 2^ADDR_WIDTH compares cleanly.
  assign two_i     = {idx_reg, 1'b0};
  assign two_i_p1  = two_i + CW'(1);
  assign two_i_p2  = two_i + CW'(2);
  assign clamped   = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign s_ready   = (state_reg == EVEN) || (state_reg == ODD);
  assign handshake = s_valid && s_ready;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      idx_reg   <= '0;
      hold_reg  <= '0;
      wr_reg    <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      addra_reg <= '0;
      addrb_reg <= '0;
      dina_reg  <= '0;
      dinb_reg  <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
      wr_reg    <= wr_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      addra_reg <= addra_next;
      addrb_reg <= addrb_next;
      dina_reg  <= dina_next;
      dinb_reg  <= dinb_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && (num_words != '0)) state_next = EVEN;
      end
      EVEN: begin
        if (handshake) state_next = (two_i_p1 == n_reg) ? IDLE : ODD;
      end
      ODD: begin
        if (handshake) state_next = (two_i_p2 == n_reg) ? IDLE : EVEN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    n_next     = n_reg;
    idx_next   = idx_reg;
    hold_next  = hold_reg;
    wr_next    = 1'b0;
    done_next  = 1'b0;
    addra_next = addra_reg;
    addrb_next = addrb_reg;
    dina_next  = dina_reg;
    dinb_next  = dinb_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            done_next = 1'b1;
          end else begin
            n_next   = clamped;
            idx_next = '0;
          end
        end
      end
      EVEN: begin
        if (handshake) begin
          hold_next = s_data;
          // Odd tail: duplicate the last word on both ports at the same address.
          if (two_i_p1 == n_reg) begin
            wr_next    = 1'b1;
            done_next  = 1'b1;
            addra_next = two_i[ADDR_WIDTH-1:0];
            addrb_next = two_i[ADDR_WIDTH-1:0];
            dina_next  = s_data;
            dinb_next  = s_data;
          end
        end
      end
      ODD: begin
        if (handshake) begin
          wr_next    = 1'b1;
          addra_next = two_i[ADDR_WIDTH-1:0];
          addrb_next = two_i_p1[ADDR_WIDTH-1:0];
          dina_next  = hold_reg;
          dinb_next  = s_data;
          idx_next   = idx_reg + ADDR_WIDTH'(1);
          if (two_i_p2 == n_reg) done_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy_next = (state_next != IDLE);

  assign in_mat_ena      = wr_reg;
  assign in_mat_wea      = wr_reg;
  assign in_mat_enb      = wr_reg;
  assign in_mat_web      = wr_reg;
  assign in_mat_wr_addra = addra_reg;
  assign in_mat_wr_addrb = addrb_reg;
  assign in_mat_dina     = dina_reg;
  assign in_mat_dinb     = dinb_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_lp_input_bram_loader.sv
// Randomized bench for lp_input_bram_loader: a word-index model predicts every write,
// done pulse and busy/ready level cycle by cycle.
module tb_lp_input_bram_loader;
  localparam int DW = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web;
  logic [AW-1:0] in_mat_wr_addra, in_mat_wr_addrb;
  logic [DW-1:0] in_mat_dina, in_mat_dinb;
  logic          busy, done;

  lp_input_bram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .in_mat_ena(in_mat_ena), .in_mat_wea(in_mat_wea),
    .in_mat_wr_addra(in_mat_wr_addra), .in_mat_dina(in_mat_dina),
    .in_mat_enb(in_mat_enb), .in_mat_web(in_mat_web),
    .in_mat_wr_addrb(in_mat_wr_addrb), .in_mat_dinb(in_mat_dinb),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a load is a list of N words; word k pairs with k-1 when k is odd,
  // and the last word of an odd-length load is written alone on both ports.
  bit            m_loading;
  int            m_n, m_k;
  logic [DW-1:0] m_words [0:511];
  logic [AW-1:0] m_addra, m_addrb;
  logic [DW-1:0] m_dina, m_dinb;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_loading = 0; m_n = 0; m_k = 0;
    m_addra = '0; m_addrb = '0; m_dina = '0; m_dinb = '0;
  endtask

  // Predict from the inputs currently driven, clock once, then compare.
  task automatic tick();
    bit exp_wr, exp_done;
    exp_wr = 0; exp_done = 0;
    if (m_loading) begin
      if (s_valid) begin
        m_words[m_k] = s_data;
        if (m_k % 2 == 1) begin
          exp_wr = 1;
          m_addra = AW'(m_k - 1); m_dina = m_words[m_k - 1];
          m_addrb = AW'(m_k);     m_dinb = s_data;
        end else if (m_k == m_n - 1) begin
          exp_wr = 1;
          m_addra = AW'(m_k); m_dina = s_data;
          m_addrb = AW'(m_k); m_dinb = s_data;
        end
        m_k++;
        if (m_k == m_n) begin
          exp_done = 1;
          m_loading = 0;
        end
      end
    end else if (start) begin
      if (num_words == 0) exp_done = 1;
      else begin
        m_loading = 1;
        m_n = (int'(num_words) > (1 << AW)) ? (1 << AW) : int'(num_words);
        m_k = 0;
      end
    end
    @(posedge clk); #1;
    chk("strobes", DW'({in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web}), DW'({4{exp_wr}}));
    chk("addra", DW'(in_mat_wr_addra), DW'(m_addra));
    chk("addrb", DW'(in_mat_wr_addrb), DW'(m_addrb));
    chk("dina", in_mat_dina, m_dina);
    chk("dinb", in_mat_dinb, m_dinb);
    chk("done", DW'(done), DW'(exp_done));
    chk("busy", DW'(busy), DW'(m_loading));
    chk("s_ready", DW'(s_ready), DW'(m_loading));
    $display("t=%0t wr=%0b a@%0d=%0h b@%0d=%0h done=%0b busy=%0b",
             $time, in_mat_wea, in_mat_wr_addra, in_mat_dina, in_mat_wr_addrb, in_mat_dinb, done, busy);
  endtask

  // mode 0: contiguous valid, 1: valid pattern 1-0-0-1, 2: random valid.
  task automatic run_load(input int n, input int mode, input bit restart_mid, input int stop_after);
    int cyc;
    start = 1; num_words = (AW+1)'(n); s_valid = 0;
    tick();
    start = 0;
    cyc = 0;
    while (m_loading && cyc < 3000 && !(stop_after >= 0 && m_k >= stop_after)) begin
      case (mode)
        0: s_valid = 1;
        1: s_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = rnd_word();
      if (restart_mid && cyc == 2) begin
        start = 1; num_words = (AW+1)'(3);
      end else start = 0;
      tick();
      cyc++;
    end
    start = 0; s_valid = 0;
    if (cyc >= 3000) chk("load_timeout", DW'(cyc), DW'(0));
    if (stop_after < 0) tick();
  endtask

  initial begin
    model_reset();
    rst_n = 0; start = 0; num_words = '0; s_valid = 0; s_data = '0;
    #12;
    chk("rst_strobes", DW'({in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web}), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_ready", DW'(s_ready), DW'(0));
    chk("rst_dina", in_mat_dina, DW'(0));
    rst_n = 1;
    @(posedge clk); #1;

    run_load(4, 0, 0, -1);
    run_load(5, 0, 0, -1);
    run_load(1, 0, 0, -1);
    run_load(0, 0, 0, -1);
    run_load(6, 1, 1, -1);

    // Reset after three words of an eight-word load: pending hold word must never appear.
    run_load(8, 0, 0, 3);
    rst_n = 0;
    #1;
    model_reset();
    chk("midrst_strobes", DW'({in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web}), DW'(0));
    chk("midrst_addra", DW'(in_mat_wr_addra), DW'(0));
    chk("midrst_dina", in_mat_dina, DW'(0));
    chk("midrst_busy", DW'(busy), DW'(0));
    chk("midrst_ready", DW'(s_ready), DW'(0));
    @(posedge clk); #1;
    chk("midrst_hold_strobes", DW'(in_mat_wea), DW'(0));
    rst_n = 1;
    @(posedge clk); #1;
    run_load(2, 0, 0, -1);

    for (int r = 0; r < 10; r++) run_load($urandom_range(0, 21), 2, r % 3 == 0, -1);
    run_load(300, 2, 0, -1);
    run_load(256, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
